// File: rtl/zoom_pkg.sv
// Shared definitions for the zoom pipeline: pixel width, default image geometry and the
// frame sequencer state encoding.
package zoom_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned IMG_W_DEF = 320;
    localparam int unsigned IMG_H_DEF = 240;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClr     = 3'd1,
        StFetch   = 3'd2,
        StDrain   = 3'd3,
        StWaitRep = 3'd4,
        StDone    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/zoom_seq_addr_gen.sv
// Running RAM read address and column counter for the frame sequencer; flags the last
// column of a row so the FSM knows when a row fetch is complete.
module zoom_seq_addr_gen
    import zoom_pkg::*;
#(
    parameter int unsigned IMG_W     = IMG_W_DEF,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [ADDR_W-1:0] addr_q;
    logic [COL_W-1:0]  col_q;

    assign addr     = addr_q;
    assign last_col = (col_q == COL_W'(IMG_W - 1));

    // Row-major layout: the address after a row's last pixel is the next row's start.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            addr_q <= ADDR_W'(BASE_ADDR);
            col_q  <= '0;
        end else if (inc) begin
            addr_q <= addr_q + 1'b1;
            col_q  <= last_col ? '0 : col_q + 1'b1;
        end
    end

endmodule

// File: rtl/zoom_frame_sequencer.sv
// Frame-level controller for the pixel replication stage: fetches rows from image RAM,
// streams them to the replicator and paces rows on its line-done pulse.
// Optional WAIT_REP watchdog with sticky o_timeout: define ZOOM_SEQ_TIMEOUT_EN.
module zoom_frame_sequencer
    import zoom_pkg::*;
#(
    parameter int unsigned IMG_W       = IMG_W_DEF,
    parameter int unsigned IMG_H       = IMG_H_DEF,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [9:0]        o_row,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd_en,
    input  logic [PIX_W-1:0]  i_mem_data,
    output logic [PIX_W-1:0]  o_pix,
    output logic              o_pix_valid,
    input  logic              i_rep_line_done,
    output logic              o_rep_rst
`ifdef ZOOM_SEQ_TIMEOUT_EN
    ,
    output logic              o_timeout
`endif
);

    if (IMG_H < 1 || IMG_H > 1024) begin : g_bad_img_h
        $error("IMG_H must be in 1..1024 to fit the 10-bit row index");
    end
    if (IMG_W < 2) begin : g_bad_img_w
        $error("IMG_W must be at least 2");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit the 16-bit watchdog");
    end

    seq_state_t state_q, state_d;
    logic       busy_q, busy_d, frame_done_q, frame_done_d;
    logic       rd_en_q, rd_en_d, pix_valid_q, pix_valid_d, rep_rst_q, rep_rst_d;
    logic [9:0] row_q, row_d;
    logic       last_col, last_row, wd_expired, abort;

    assign last_row = (row_q == 10'(IMG_H - 1));
    assign abort    = (i_abort || wd_expired) && (state_q != StIdle);

    zoom_seq_addr_gen #(
        .IMG_W    (IMG_W),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (state_q == StClr),
        .inc     ((state_q == StFetch) && !abort),
        .addr    (o_mem_addr),
        .last_col(last_col)
    );

`ifdef ZOOM_SEQ_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        timeout_q;

    // Line-done wins over an expiry in the same cycle.
    assign wd_expired = (state_q == StWaitRep) && !i_rep_line_done
                        && (wd_q == 16'(TIMEOUT_CYC - 1));
    assign o_timeout  = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != StWaitRep) wd_q <= '0;
            else                      wd_q <= wd_q + 1'b1;
            if (wd_expired)                                  timeout_q <= 1'b1;
            else if (state_q == StIdle && i_start && !i_abort) timeout_q <= 1'b0;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_en_q      <= 1'b0;
            pix_valid_q  <= 1'b0;
            rep_rst_q    <= 1'b0;
            row_q        <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            rd_en_q      <= rd_en_d;
            pix_valid_q  <= pix_valid_d;
            rep_rst_q    <= rep_rst_d;
            row_q        <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (i_start && !i_abort) state_d = StClr;
                StClr:     state_d = StFetch;
                StFetch:   if (last_col) state_d = StDrain;
                StDrain:   state_d = StWaitRep;
                StWaitRep: if (i_rep_line_done) state_d = last_row ? StDone : StFetch;
                StDone:    state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy_d       = (state_d != StIdle);
        frame_done_d = (state_d == StDone);
        rd_en_d      = (state_d == StFetch);
        rep_rst_d    = (state_d == StClr) || abort;
        // An aborted frame must not leak its in-flight pixel to the replicator.
        pix_valid_d  = rd_en_q && !abort;
        row_d        = row_q;
        if (state_d == StClr) begin
            row_d = '0;
        end else if (state_q == StWaitRep && state_d == StFetch) begin
            row_d = row_q + 1'b1;
        end
    end

    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;
    assign o_row        = row_q;
    assign o_mem_rd_en  = rd_en_q;
    assign o_pix_valid  = pix_valid_q;
    assign o_rep_rst    = rep_rst_q;
    assign o_pix        = pix_valid_q ? i_mem_data : '0;

endmodule
